// File: rtl/nes_pad_receiver_pkg.sv
// Shared definitions for the NES pad receiver: button bit positions, FSM states and
// default pin timing.
package nes_pad_receiver_pkg;

    localparam int unsigned NesA      = 0;
    localparam int unsigned NesB      = 1;
    localparam int unsigned NesSelect = 2;
    localparam int unsigned NesStart  = 3;
    localparam int unsigned NesUp     = 4;
    localparam int unsigned NesDown   = 5;
    localparam int unsigned NesLeft   = 6;
    localparam int unsigned NesRight  = 7;

    // 6 us half bit and 12 us latch at a 25 MHz clock
    localparam int unsigned ClkDivDefault      = 150;
    localparam int unsigned LatchCyclesDefault = 300;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLatch = 3'd1,
        StLow   = 3'd2,
        StHigh  = 3'd3,
        StDone  = 3'd4
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/nes_pad_receiver_sync_2ff.sv
// Two-flop synchroniser for an asynchronous input pin; resets to the idle-high level.
module nes_pad_receiver_sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/nes_pad_receiver.sv
// NES/4021 pad front end: on poll, strobes latch, clocks out 8 bits and publishes them
// as one active-high button word with a single-cycle valid pulse.
module nes_pad_receiver
    import nes_pad_receiver_pkg::*;
#(
    parameter int unsigned ClkDiv      = ClkDivDefault,
    parameter int unsigned LatchCycles = LatchCyclesDefault
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       poll,
    input  logic       nes_data,
    output logic       nes_latch,
    output logic       nes_clk,
    output logic [7:0] buttons,
    output logic       valid,
    output logic       busy
);

    localparam int unsigned CntW = cnt_width(ClkDiv, LatchCycles);
    localparam logic [CntW-1:0] ClkLast   = CntW'(ClkDiv - 1);
    localparam logic [CntW-1:0] LatchLast = CntW'(LatchCycles - 1);

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      idx_q;
    logic [7:0]      shadow_q;
    logic [7:0]      buttons_q;
    logic            valid_q;
    logic            busy_q;
    logic            latch_q;
    logic            clk_q;
    logic            data_sync;

    nes_pad_receiver_sync_2ff u_data_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (nes_data),
        .q_o   (data_sync)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            buttons_q <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            latch_q   <= 1'b0;
            clk_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (poll) begin
                        state_q <= StLatch;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        latch_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                StLatch: begin
                    if (cnt_q == LatchLast) begin
                        cnt_q   <= '0;
                        latch_q <= 1'b0;
                        state_q <= StLow;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StLow: begin
                    if (cnt_q == ClkLast) begin
                        // Pad data is active-low; sample just before the rising edge.
                        cnt_q           <= '0;
                        shadow_q[idx_q] <= ~data_sync;
                        clk_q           <= 1'b1;
                        state_q         <= StHigh;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StHigh: begin
                    if (cnt_q == ClkLast) begin
                        cnt_q <= '0;
                        clk_q <= 1'b0;
                        if (idx_q == 3'd7) begin
                            state_q   <= StDone;
                            buttons_q <= shadow_q;
                            valid_q   <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            state_q <= StLow;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    latch_q <= 1'b0;
                    clk_q   <= 1'b0;
                end
            endcase
        end
    end

    assign nes_latch = latch_q;
    assign nes_clk   = clk_q;
    assign buttons   = buttons_q;
    assign valid     = valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_nes_pad_receiver.sv
// Directed bench for nes_pad_receiver against a behavioural 4021 shift-register pad.
module tb_nes_pad_receiver;

    localparam int unsigned ClkDiv      = 4;
    localparam int unsigned LatchCycles = 6;
    localparam int unsigned Latency     = LatchCycles + 16 * ClkDiv;
    localparam int unsigned MaxWait     = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       poll = 1'b0;
    logic       nes_data;
    logic       nes_latch;
    logic       nes_clk;
    logic [7:0] buttons;
    logic       valid;
    logic       busy;

    logic [7:0] pad_raw = 8'hFF;
    logic [7:0] sr = 8'hFF;
    logic       tie_en = 1'b0;
    logic       tie_val = 1'b1;

    int n_checks = 0;
    int n_err = 0;

    nes_pad_receiver #(
        .ClkDiv      (ClkDiv),
        .LatchCycles (LatchCycles)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .poll      (poll),
        .nes_data  (nes_data),
        .nes_latch (nes_latch),
        .nes_clk   (nes_clk),
        .buttons   (buttons),
        .valid     (valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // 4021: parallel load while latch high, shift toward Q8 on clock rise, serial-in high.
    always @(posedge nes_clk or posedge nes_latch) begin
        if (nes_latch) sr <= pad_raw;
        else           sr <= {1'b1, sr[7:1]};
    end

    assign nes_data = tie_en ? tie_val : sr[0];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Polls once, then follows the pin waveform until valid or the cycle budget runs out.
    task automatic do_read(input string tag, input logic [7:0] pressed,
                           input logic [7:0] exp_btn, input bit extra_polls);
        int         cyc;
        int         latch_n;
        int         pulses;
        int         hi_run;
        int         lo_run;
        int         bad_run;
        int         overlap;
        int         partial;
        logic       prev_clk;
        logic [7:0] old_btn;
        pad_raw  = ~pressed;
        old_btn  = buttons;
        cyc      = 0;
        latch_n  = 0;
        pulses   = 0;
        hi_run   = 0;
        lo_run   = 0;
        bad_run  = 0;
        overlap  = 0;
        partial  = 0;
        prev_clk = 1'b0;
        @(negedge clk);
        poll = 1'b1;
        @(negedge clk);
        poll = 1'b0;
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        while (1) begin
            if (nes_latch) latch_n++;
            if (nes_latch && nes_clk) overlap++;
            if (nes_clk && !prev_clk) begin
                pulses++;
                if (lo_run != ClkDiv) bad_run++;
                lo_run = 0;
            end
            if (!nes_clk && prev_clk) begin
                if (hi_run != ClkDiv) bad_run++;
                hi_run = 0;
            end
            if (nes_clk) hi_run++;
            else if (!nes_latch) lo_run++;
            prev_clk = nes_clk;
            if (valid) break;
            if (buttons !== old_btn) partial++;
            if (cyc >= MaxWait) break;
            @(negedge clk);
            cyc++;
            poll = extra_polls && (cyc == 10 || cyc == 40);
        end
        poll = 1'b0;
        check_eq({tag, "_latency"}, 32'(cyc), 32'(Latency));
        check_eq({tag, "_buttons"}, 32'(buttons), 32'(exp_btn));
        check_eq({tag, "_no_partial"}, 32'(partial), 32'd0);
        check_eq({tag, "_latch_len"}, 32'(latch_n), 32'(LatchCycles));
        check_eq({tag, "_pulses"}, 32'(pulses), 32'd8);
        check_eq({tag, "_run_len"}, 32'(bad_run), 32'd0);
        check_eq({tag, "_clk_in_latch"}, 32'(overlap), 32'd0);
    endtask

    initial begin
        int stray;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_outputs", {28'd0, nes_latch, nes_clk, valid, busy}, 32'd0);
        check_eq("rst_buttons", 32'(buttons), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("idle_busy", 32'(busy), 32'd0);

        // Single read with pin timing: A + Right
        do_read("single", 8'h81, 8'h81, 1'b0);

        // Async reset in the HIGH phase of bit 3 discards the read
        pad_raw = ~8'h3C;
        @(negedge clk);
        poll = 1'b1;
        @(negedge clk);
        poll = 1'b0;
        repeat (35) @(negedge clk);
        check_eq("pre_reset_clk_high", 32'(nes_clk), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("midread_rst_outputs", {28'd0, nes_latch, nes_clk, valid, busy}, 32'd0);
        check_eq("midread_rst_buttons", 32'(buttons), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        stray = 0;
        repeat (12) begin
            @(negedge clk);
            if (valid || busy || nes_latch || nes_clk) stray++;
        end
        check_eq("post_rst_quiet", 32'(stray), 32'd0);
        check_eq("post_rst_buttons", 32'(buttons), 32'd0);
        do_read("after_rst", 8'h3C, 8'h3C, 1'b0);

        // Polls while busy are ignored; nothing starts until the next idle poll
        do_read("busy_polls", 8'h05, 8'h05, 1'b1);
        stray = 0;
        repeat (6) begin
            @(negedge clk);
            if (valid || busy) stray++;
        end
        check_eq("busy_polls_single_valid", 32'(stray), 32'd0);
        do_read("next_poll", 8'h40, 8'h40, 1'b0);

        // Poll landing in the DONE cycle is dropped
        poll = 1'b1;
        @(negedge clk);
        poll = 1'b0;
        stray = 0;
        repeat (4) begin
            if (busy || valid) stray++;
            @(negedge clk);
        end
        check_eq("done_poll_ignored", 32'(stray), 32'd0);

        // Unplugged, then everything pressed
        tie_en  = 1'b1;
        tie_val = 1'b1;
        do_read("unplugged", 8'h00, 8'h00, 1'b0);
        tie_val = 1'b0;
        do_read("all_pressed", 8'hFF, 8'hFF, 1'b0);
        stray = 0;
        repeat (20) begin
            @(negedge clk);
            if (buttons !== 8'hFF || valid) stray++;
        end
        check_eq("hold_between_reads", 32'(stray), 32'd0);
        tie_en = 1'b0;

        // Back-to-back: next poll in the cycle right after valid
        do_read("b2b_up", 8'h10, 8'h10, 1'b0);
        do_read("b2b_down", 8'h20, 8'h20, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
